// File: rtl/ipsmacge_pkg.sv
// Shared types for the GE MAC link-speed sequencer: FSM state codes, speed codes,
// tx clock-select codes and the speed-to-clock mapping.
package ipsmacge_pkg;

  typedef enum logic [2:0] {
    ST_DOWN   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_SETTLE = 3'd4
  } spd_state_e;

  localparam logic [1:0] SPD_10M  = 2'b00;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_1G   = 2'b10;

  localparam logic [1:0] SEL_REF    = 2'b00;
  localparam logic [1:0] SEL_PIN2M5 = 2'b01;
  localparam logic [1:0] SEL_PLL125 = 2'b10;
  localparam logic [1:0] SEL_PLL25  = 2'b11;

  typedef struct packed {
    logic       link;
    logic [1:0] spd;
  } lnk_sta_t;

  // Any speed with bit 1 set is treated as 1G.
  function automatic logic [1:0] clk_map(input logic [1:0] spd, input logic gmii);
    logic [1:0] sel;
    if (spd[1])
      sel = SEL_PLL125;
    else if (gmii)
      sel = SEL_REF;
    else if (spd[0])
      sel = SEL_PLL25;
    else
      sel = SEL_PIN2M5;
    return sel;
  endfunction

endpackage

// File: rtl/ipsmacge_spdflt.sv
// In-band link/speed status debounce: a new value is accepted only after STBCNT
// consecutive identical valid samples; invalid cycles are ignored entirely.
module ipsmacge_spdflt
  import ipsmacge_pkg::*;
#(
  parameter int STBCNT = 4
) (
  input  logic       txclk,
  input  logic       txrst_,
  input  logic       iifovld,
  input  logic [7:0] iifodat,
  output lnk_sta_t   flt
);

  localparam int RW = $clog2(STBCNT + 1) + 1;

  lnk_sta_t        cand;
  lnk_sta_t        prev;
  logic [RW-1:0]   runcnt;
  logic [RW-1:0]   run_nxt;
  logic            unused_dat;

  // Duplex and the upper status bits carry nothing the sequencer needs.
  assign unused_dat = ^{iifodat[7:3]};
  assign cand       = lnk_sta_t'({iifodat[0], iifodat[2:1]});

  // runcnt==0 only before the first valid sample after reset.
  always_comb begin
    run_nxt = RW'(1);
    if (runcnt != '0 && cand == prev) begin
      if (runcnt == RW'(STBCNT))
        run_nxt = runcnt;
      else
        run_nxt = runcnt + RW'(1);
    end
  end

  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      prev   <= '0;
      runcnt <= '0;
      flt    <= '0;
    end else if (iifovld) begin
      prev   <= cand;
      runcnt <= run_nxt;
      if (run_nxt == RW'(STBCNT))
        flt <= cand;
    end
  end

endmodule

// File: rtl/ipsmacge_spdseq.sv
// GE MAC link-speed sequencer: holds tx, waits for drain, reprograms clock select and
// speed, waits for settle and releases. Optional change counter: IPSMACGE_SPDSEQ_CHGCNT_EN.
//
// state  | meaning
// DOWN   | no link; tx held
// RUN    | link up at applied speed; tx released
// DRAIN  | change pending; tx held, waiting for framer idle or timeout
// SWITCH | one cycle; new speed and clock select applied on exit
// SETTLE | tx held while the new tx clock settles
module ipsmacge_spdseq
  import ipsmacge_pkg::*;
#(
  parameter int STBCNT = 4,
  parameter int SETTLE = 16,
  parameter int DRNTMO = 1024,
  parameter int CW     = 8
) (
  input  logic          txclk,
  input  logic          txrst_,
  input  logic          iifovld,
  input  logic [7:0]    iifodat,
  input  logic          itxidle,
  input  logic          pautodis,
  input  logic [1:0]    pmodspd,
  input  logic          pmodgmii,
  input  logic          pclrcnt,
  output logic          otxhold,
  output logic [1:0]    oselclk,
  output logic [1:0]    omodspd,
  output logic          olinkup,
  output logic          ochgint,
  output logic          oddrntmo,
  output logic [2:0]    stastate
`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
  ,
  output logic [CW-1:0] stachgcnt
`endif
);

  localparam int TMAX = (DRNTMO > SETTLE) ? DRNTMO : SETTLE;
  localparam int TW   = $clog2(TMAX) + 1;

  spd_state_e    state;
  lnk_sta_t      flt;
  lnk_sta_t      tgt;
  logic [1:0]    tgt_sel;
  logic [TW-1:0] tmr;
  logic          settle_done;

  ipsmacge_spdflt #(
    .STBCNT (STBCNT)
  ) u_spdflt (
    .txclk   (txclk),
    .txrst_  (txrst_),
    .iifovld (iifovld),
    .iifodat (iifodat),
    .flt     (flt)
  );

  // Forced mode bypasses the filter and implies link up.
  assign tgt         = pautodis ? lnk_sta_t'({1'b1, pmodspd}) : flt;
  assign tgt_sel     = clk_map(tgt.spd, pmodgmii);
  assign settle_done = (state == ST_SETTLE) && tgt.link && (tgt.spd == omodspd) && (tmr == '0);
  assign stastate    = state;

  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      state    <= ST_DOWN;
      otxhold  <= 1'b1;
      omodspd  <= SPD_1G;
      oselclk  <= SEL_PLL125;
      olinkup  <= 1'b0;
      ochgint  <= 1'b0;
      oddrntmo <= 1'b0;
      tmr      <= '0;
    end else begin
      // Hold and link status follow the state one cycle late, so the clock
      // select (changed only on SWITCH exit) is always covered by the hold.
      otxhold <= (state != ST_RUN);
      olinkup <= (state == ST_RUN);
      ochgint <= 1'b0;
      if (pclrcnt)
        oddrntmo <= 1'b0;
      case (state)
        ST_DOWN: begin
          if (tgt.link)
            state <= ST_SWITCH;
        end
        ST_SWITCH: begin
          omodspd <= tgt.spd;
          oselclk <= tgt_sel;
          if (!tgt.link) begin
            state <= ST_DOWN;
          end else begin
            state <= ST_SETTLE;
            tmr   <= TW'(SETTLE - 1);
          end
        end
        ST_SETTLE: begin
          if (!tgt.link)
            state <= ST_DOWN;
          else if (tgt.spd != omodspd)
            state <= ST_SWITCH;
          else if (settle_done) begin
            state   <= ST_RUN;
            ochgint <= 1'b1;
          end else
            tmr <= tmr - TW'(1);
        end
        ST_RUN: begin
          if (!tgt.link || tgt.spd != omodspd || tgt_sel != oselclk) begin
            state <= ST_DRAIN;
            tmr   <= TW'(DRNTMO - 1);
          end
        end
        ST_DRAIN: begin
          if (itxidle)
            state <= ST_SWITCH;
          else if (tmr == '0) begin
            state    <= ST_SWITCH;
            oddrntmo <= 1'b1;
          end else
            tmr <= tmr - TW'(1);
        end
        default: state <= ST_DOWN;
      endcase
    end
  end

`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_)
      stachgcnt <= '0;
    else if (pclrcnt)
      stachgcnt <= '0;
    else if (settle_done)
      stachgcnt <= stachgcnt + CW'(1);
  end
`else
  localparam int cw_unused = CW;
`endif

endmodule

// File: tb/tb_ipsmacge_spdseq.sv
// Self-checking bench for ipsmacge_spdseq: directed scenarios plus randomized speed
// changes checked against a behavioural model of the filter and clock map.
module tb_ipsmacge_spdseq;

  localparam int STBCNT = 4;
  localparam int SETTLE = 16;
  localparam int DRNTMO = 1024;
  localparam int CW     = 8;

  localparam logic [2:0] S_DOWN = 3'd0, S_RUN = 3'd1, S_DRAIN = 3'd2,
                         S_SWITCH = 3'd3, S_SETTLE = 3'd4;

  logic          txclk = 1'b0;
  logic          txrst_;
  logic          iifovld;
  logic [7:0]    iifodat;
  logic          itxidle;
  logic          pautodis;
  logic [1:0]    pmodspd;
  logic          pmodgmii;
  logic          pclrcnt;
  logic          otxhold;
  logic [1:0]    oselclk;
  logic [1:0]    omodspd;
  logic          olinkup;
  logic          ochgint;
  logic          oddrntmo;
  logic [2:0]    stastate;
`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
  logic [CW-1:0] stachgcnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] vq[$];
  logic [2:0] m_flt;

  ipsmacge_spdseq #(
    .STBCNT (STBCNT),
    .SETTLE (SETTLE),
    .DRNTMO (DRNTMO),
    .CW     (CW)
  ) dut (
    .txclk    (txclk),
    .txrst_   (txrst_),
    .iifovld  (iifovld),
    .iifodat  (iifodat),
    .itxidle  (itxidle),
    .pautodis (pautodis),
    .pmodspd  (pmodspd),
    .pmodgmii (pmodgmii),
    .pclrcnt  (pclrcnt),
    .otxhold  (otxhold),
    .oselclk  (oselclk),
    .omodspd  (omodspd),
    .olinkup  (olinkup),
    .ochgint  (ochgint),
    .oddrntmo (oddrntmo),
    .stastate (stastate)
`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
    ,
    .stachgcnt (stachgcnt)
`endif
  );

  always #5 txclk = ~txclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_sel(input logic [1:0] spd, input logic gmii);
    logic [1:0] r;
    if (gmii)
      r = (spd >= 2'd2) ? 2'b10 : 2'b00;
    else if (spd == 2'd0)
      r = 2'b01;
    else if (spd == 2'd1)
      r = 2'b11;
    else
      r = 2'b10;
    return r;
  endfunction

  // Filter model: the accepted value is whatever the last STBCNT valid samples agree on.
  task automatic model_push(input logic [2:0] s);
    int run;
    vq.push_back(s);
    if (vq.size() > 8)
      void'(vq.pop_front());
    run = 0;
    for (int i = vq.size() - 1; i >= 0; i--) begin
      if (vq[i] != s) break;
      run++;
    end
    if (run >= STBCNT)
      m_flt = s;
  endtask

  task automatic cyc;
    @(posedge txclk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      iifovld = 1'b0;
      iifodat = 8'($urandom);
      cyc();
    end
    iifovld = 1'b1;
    iifodat = b;
    cyc();
    iifovld = 1'b0;
    model_push({b[0], b[2:1]});
  endtask

  task automatic wait_st(input logic [2:0] st, input int lim, output int n);
    n = 0;
    while (stastate !== st && n < lim) begin
      cyc();
      n++;
    end
    if (stastate !== st)
      chk("wait_state_timeout", stastate, st);
  endtask

  task automatic reset_chk(input string pfx);
    chk({pfx, "_state"},  stastate, S_DOWN);
    chk({pfx, "_hold"},   otxhold,  1'b1);
    chk({pfx, "_modspd"}, omodspd,  2'b10);
    chk({pfx, "_selclk"}, oselclk,  2'b10);
    chk({pfx, "_linkup"}, olinkup,  1'b0);
    chk({pfx, "_chgint"}, ochgint,  1'b0);
    chk({pfx, "_drntmo"}, oddrntmo, 1'b0);
`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
    chk({pfx, "_chgcnt"}, stachgcnt, '0);
`endif
  endtask

  // Clock select must never move while tx is released.
  logic       prev_vld = 1'b0;
  logic       prev_hold;
  logic [1:0] prev_sel;
  always @(negedge txclk) begin
    if (!txrst_) begin
      prev_vld <= 1'b0;
    end else begin
      if (prev_vld && !prev_hold)
        chk("selclk_stable_in_run", oselclk, prev_sel);
      prev_vld  <= 1'b1;
      prev_hold <= otxhold;
      prev_sel  <= oselclk;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] spd;
    logic       lnk;
    logic       gm;
    logic [7:0] b;
    logic [7:0] t2[6];

    txrst_ = 1'b0; iifovld = 1'b0; iifodat = '0; itxidle = 1'b0;
    pautodis = 1'b0; pmodspd = 2'b00; pmodgmii = 1'b0; pclrcnt = 1'b0;
    m_flt = '0;
    repeat (3) cyc();
    reset_chk("rst");
    txrst_ = 1'b1;
    cyc();

    // 1: link up at 1G RGMII via in-band status
    for (int i = 0; i < 4; i++) send(8'h05, $urandom_range(0, 3));
    chk("t1_not_yet", stastate, S_DOWN);
    wait_st(S_SWITCH, 10, n);
    chk("t1_switch_lat", n, 1);
    wait_st(S_RUN, 40, n);
    chk("t1_settle_lat", n, SETTLE + 1);
    chk("t1_chgint", ochgint, 1'b1);
    cyc();
    chk("t1_chgint_off", ochgint, 1'b0);
    chk("t1_hold",   otxhold, 1'b0);
    chk("t1_linkup", olinkup, 1'b1);
    chk("t1_selclk", oselclk, ref_sel(m_flt[1:0], 1'b0));
    chk("t1_modspd", omodspd, m_flt[1:0]);
`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
    chk("t1_chgcnt", stachgcnt, 1);
`endif

    // 2: debounce; broken runs must not disturb RUN
    t2 = '{8'h03, 8'h03, 8'h05, 8'h03, 8'h03, 8'h03};
    for (int i = 0; i < 6; i++) begin
      send(t2[i], $urandom_range(0, 3));
      chk("t2_stay_run", stastate, S_RUN);
      chk("t2_hold_low", otxhold, 1'b0);
    end
    send(8'h03, 2);
    wait_st(S_DRAIN, 10, n);
    chk("t2_drain_lat", n, 1);

    // 3: drain waits for idle
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("t3_drain_state", stastate, S_DRAIN);
      chk("t3_drain_hold", otxhold, 1'b1);
    end
    itxidle = 1'b1;
    cyc();
    chk("t3_switch_after_idle", stastate, S_SWITCH);
    itxidle = 1'b0;
    wait_st(S_RUN, 40, n);
    cyc();
    chk("t3_selclk", oselclk, ref_sel(m_flt[1:0], 1'b0));
    chk("t3_modspd", omodspd, m_flt[1:0]);
    chk("t3_drntmo", oddrntmo, 1'b0);
`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
    chk("t3_chgcnt", stachgcnt, 2);
`endif

    // 4: drain timeout
    for (int i = 0; i < 4; i++) send(8'h05, $urandom_range(0, 2));
    wait_st(S_DRAIN, 10, n);
    chk("t4_drain_lat", n, 1);
    wait_st(S_SWITCH, DRNTMO + 50, n);
    chk("t4_timeout_len", n, DRNTMO);
    chk("t4_drntmo_set", oddrntmo, 1'b1);
    pclrcnt = 1'b1;
    cyc();
    chk("t4_drntmo_clr", oddrntmo, 1'b0);
`ifdef IPSMACGE_SPDSEQ_CHGCNT_EN
    chk("t4_chgcnt_clr", stachgcnt, 0);
`endif
    pclrcnt = 1'b0;
    wait_st(S_RUN, 40, n);
    cyc();
    chk("t4_modspd", omodspd, 2'b10);

    // 5: forced mode, then link drop during SETTLE
    itxidle = 1'b1;
    pautodis = 1'b1; pmodspd = 2'b00; pmodgmii = 1'b1;
    wait_st(S_DRAIN, 10, n);
    chk("t5_drain_lat", n, 1);
    wait_st(S_RUN, 40, n);
    cyc();
    chk("t5_selclk", oselclk, ref_sel(2'b00, 1'b1));
    chk("t5_modspd", omodspd, 2'b00);
    chk("t5_linkup", olinkup, 1'b1);
    for (int i = 0; i < 4; i++) send(8'h00, $urandom_range(0, 2));
    chk("t5_forced_ignores_inband", stastate, S_RUN);
    pmodspd = 2'b01;
    wait_st(S_SETTLE, 10, n);
    repeat (3) cyc();
    pautodis = 1'b0;
    cyc();
    chk("t5_drop_to_down", stastate, S_DOWN);
    cyc();
    chk("t5_linkup_low", olinkup, 1'b0);
    chk("t5_hold_high", otxhold, 1'b1);

    // 6: async reset during SETTLE
    pautodis = 1'b1; pmodspd = 2'b10;
    wait_st(S_SETTLE, 10, n);
    repeat (5) cyc();
    #2 txrst_ = 1'b0;
    #1 reset_chk("t6");
    pautodis = 1'b0;
    vq.delete();
    m_flt = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_chgint", ochgint, 1'b0);
    end
    txrst_ = 1'b1;
    cyc();

    // randomized speed changes via forced or in-band status
    for (int ep = 0; ep < 30; ep++) begin
      spd = 2'($urandom_range(0, 3));
      lnk = ($urandom_range(0, 5) != 0);
      gm  = 1'($urandom_range(0, 1));
      itxidle  = 1'($urandom_range(0, 1));
      pmodgmii = gm;
      if ($urandom_range(0, 1) == 1) begin
        pautodis = 1'b1;
        pmodspd  = spd;
        lnk      = 1'b1;
      end else begin
        pautodis = 1'b0;
        for (int k = $urandom_range(0, 3); k > 0; k--)
          send(8'($urandom), $urandom_range(0, 3));
        for (int k = 0; k < STBCNT; k++) begin
          b = {5'($urandom), spd, lnk};
          send(b, $urandom_range(0, 3));
        end
        lnk = m_flt[2];
        spd = m_flt[1:0];
      end
      itxidle = 1'b1;
      repeat (3) cyc();
      if (lnk) begin
        wait_st(S_RUN, 200, n);
        cyc();
        chk("rnd_state",  stastate, S_RUN);
        chk("rnd_modspd", omodspd, spd);
        chk("rnd_selclk", oselclk, ref_sel(spd, gm));
        chk("rnd_linkup", olinkup, 1'b1);
      end else begin
        wait_st(S_DOWN, 200, n);
        cyc();
        chk("rnd_down_linkup", olinkup, 1'b0);
        chk("rnd_down_hold", otxhold, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
